// File: rtl/div_seq.sv
// ============================================================================
// Module      : div_seq
// Description : 32-bit sequential restoring divider (DIV/DIVU) producing a
//               HI remainder and a LO quotient. Define DIV_ZERO_FAST_EN to
//               complete b=0 divides in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        res_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_LAST_ITER = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_bzero;

    logic        w_accept;
    logic        w_fast;
    logic        w_last;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_borrow;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_hi_fin;
    logic [31:0] w_lo_fin;

    assign w_accept = (r_state == IDLE) & start & ~annul;
    assign w_last   = (r_state == BUSY) & (r_cnt == c_LAST_ITER) & ~annul;

`ifdef DIV_ZERO_FAST_EN
    assign w_fast = w_accept & (b == 32'd0);
`else
    assign w_fast = 1'b0;
`endif

    assign w_a_mag = (signed_div & a[31]) ? (~a + 32'd1) : a;
    assign w_b_mag = (signed_div & b[31]) ? (~b + 32'd1) : b;

    // The partial remainder stays below the divisor, so a set bit 32 in the
    // difference can only mean the trial subtraction borrowed.
    assign w_rem_sh  = {r_rem, r_quo[31]};
    assign w_diff    = w_rem_sh - {1'b0, r_div};
    assign w_borrow  = w_diff[32];
    assign w_rem_nxt = w_borrow ? w_rem_sh[31:0] : w_diff[31:0];
    assign w_quo_nxt = {r_quo[30:0], ~w_borrow};

    assign w_lo_fin = r_bzero  ? 32'hFFFF_FFFF
                    : (r_sign_q ? (~w_quo_nxt + 32'd1) : w_quo_nxt);
    assign w_hi_fin = r_sign_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (annul) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_LAST_ITER) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_div    <= 32'd0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_bzero  <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt    <= 5'd0;
                r_quo    <= w_a_mag;
                r_rem    <= 32'd0;
                r_div    <= w_b_mag;
                r_sign_q <= signed_div & (a[31] ^ b[31]);
                r_sign_r <= signed_div & a[31];
                r_bzero  <= (b == 32'd0);
            end
            if ((r_state == BUSY) && !annul) begin
                r_cnt <= r_cnt + 5'd1;
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
            end
            if (w_fast) begin
                hi_o <= a;
                lo_o <= 32'hFFFF_FFFF;
            end else if (w_last) begin
                hi_o <= w_hi_fin;
                lo_o <= w_lo_fin;
            end
        end
    end

    assign res_valid = (r_state == DONE) & ~annul;
    assign busy      = (r_state == BUSY);

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module      : tb_div_seq
// Description : Self-checking bench for div_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        res_valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    int          m_left = 0;
    bit          m_done = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;

    div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .res_valid  (res_valid),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Arithmetic reference: MIPS DIV/DIVU semantics incl. b=0 and overflow.
    function automatic void model_div(input logic [31:0] x, input logic [31:0] y, input bit s,
                                      output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = sx / sy;
            r = sx % sy;
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (annul && (m_left > 0 || m_done)) begin
            m_left = 0;
            m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_hi   = p_hi;
                m_lo   = p_lo;
            end
        end else if (start && !annul) begin
            model_div(a, b, signed_div, p_lo, p_hi);
`ifdef DIV_ZERO_FAST_EN
            if (b == 32'd0) begin
                m_done = 1;
                m_hi   = p_hi;
                m_lo   = p_lo;
            end else begin
                m_left = 32;
            end
`else
            m_left = 32;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("cyc_res_valid", {31'd0, res_valid}, {31'd0, (m_done && !annul)});
            check("cyc_hi", hi_o, m_hi);
            check("cyc_lo", lo_o, m_lo);
        end
    end

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input bit ts,
                          input logic [31:0] elo, input logic [31:0] ehi, input string nm);
        int n;
        int exp_lat;
        @(posedge clk); #2;
        a = ta; b = tb; signed_div = ts; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 40);
        exp_lat = 33;
`ifdef DIV_ZERO_FAST_EN
        if (tb == 32'd0) exp_lat = 1;
`endif
        check({nm, "_latency"}, n, exp_lat);
        check({nm, "_lo"}, lo_o, elo);
        check({nm, "_hi"}, hi_o, ehi);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        a = 32'd0; b = 32'd0;
        @(posedge clk); #2;
        chk_en = 1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, res_valid}, 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s_m7_2");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, "u_fff9_2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "s_ovf");
        run_op(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, "u_div0");
        run_op(32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00, "s_div0_neg");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "s_7_m2");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, "u_max_1");
        run_op(32'h8000_0000, 32'd3, 1'b1, 32'hD555_5556, 32'hFFFF_FFFE, "s_min_3");

        // Kill an operation partway through, then restart immediately.
        @(posedge clk); #2;
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 annul = 1'b1;
        @(negedge clk);
        check("annul_valid", {31'd0, res_valid}, 32'd0);
        check("annul_busy_now", {31'd0, busy}, 32'd1);
        @(posedge clk); #2;
        annul = 1'b0;
        @(negedge clk);
        check("annul_busy_next", {31'd0, busy}, 32'd0);
        check("annul_hi_hold", hi_o, 32'hFFFF_FFFE);
        check("annul_lo_hold", lo_o, 32'hD555_5556);
        run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "u9_3_after_annul");

        // Reset in the middle of an operation.
        @(posedge clk); #2;
        a = 32'h0000_FFFF; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_hi", hi_o, 32'd0);
        check("rst_mid_lo", lo_o, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        count_pulses(40, pulses);
        check("rst_mid_no_pulse", pulses, 0);

        // A start pulse during BUSY must not queue a second operation.
        @(posedge clk); #2;
        a = 32'd1000; b = 32'd10; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        check("busy_start_one_result", pulses, 1);
        check("busy_start_lo", lo_o, 32'd100);
        check("busy_start_hi", hi_o, 32'd0);

        // Annul during the DONE cycle suppresses the strobe.
        @(posedge clk); #2;
        a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (32) @(posedge clk);
        #2 annul = 1'b1;
        @(negedge clk);
        check("done_annul_valid", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #2;
        annul = 1'b0;
        count_pulses(5, pulses);
        check("done_annul_no_pulse", pulses, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request a divide; sampled only in IDLE.
REQ-004 signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-005 annul  input  1  exception flush; kills any in-flight operation.
REQ-006 a  input  32  dividend; sampled with start.
REQ-007 b  input  32  divisor; sampled with start.
REQ-008 hi_o  output  32  remainder; feeds HI write data.
REQ-009 lo_o  output  32  quotient; feeds LO write data.
REQ-010 res_valid  output  1  result-valid strobe to HI/LO write (both halves written together).
REQ-011 busy  output  1  operation in flight; pipeline stall request.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-013 IDLE + start=1 + annul=0 at edge T SHALL capture operands and signedness into internal registers and enter BUSY.
REQ-014 BUSY SHALL perform one restoring radix-2 iteration per edge on operand magnitudes, using a 5-bit counter for exactly 32 iterations.
REQ-015 After the 32nd iteration edge (T+32), the block SHALL enter DONE; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-016 res_valid SHALL equal (state==DONE) & ~annul; it is high for exactly one cycle per completed operation.
REQ-017 busy SHALL be 1 in BUSY, 0 in IDLE and DONE.
REQ-018 start in BUSY or DONE SHALL be ignored; it is not queued.
REQ-019 Signed mode: quotient SHALL be negated when operand signs differ; remainder SHALL take the dividend's sign.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo_o=0x80000000, hi_o=0; no trap, no flag.
REQ-021 b=0 (either mode) SHALL yield lo_o=0xFFFFFFFF, hi_o=a.
REQ-022 hi_o/lo_o SHALL update only on the edge entering DONE and SHALL hold until the next completion.
REQ-023 annul=1 in BUSY or DONE SHALL force IDLE at the next edge and suppress res_valid in the current cycle; hi_o/lo_o are not updated.
REQ-024 annul=1 coincident with start in IDLE SHALL prevent acceptance.
REQ-025 In signed mode, all 32 operand bits SHALL be used; no width truncation.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, counter=0, hi_o=0, lo_o=0, res_valid=0, busy=0; this takes priority over annul and start.
REQ-027 Reset mid-operation SHALL discard the operation with no res_valid pulse.

Configuration
REQ-028 Macro DIV_ZERO_FAST_EN defined: an accepted start with b=0 SHALL go directly IDLE->DONE (res_valid at T+1), with the values of REQ-021.
REQ-029 DIV_ZERO_FAST_EN undefined: b=0 SHALL take the full 32-iteration path (res_valid at T+33), with the same values.

Verification
REQ-030 Unsigned 100/7, start at T -> res_valid only in the cycle after edge T+32; lo_o=14, hi_o=2; busy high for 32 cycles.
REQ-031 Signed -7/2 (0xFFFFFFF9/0x2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; then unsigned 0xFFFFFFF9/2 -> lo_o=0x7FFFFFFC, hi_o=1.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-033 a=0x1234, b=0 -> lo_o=0xFFFFFFFF, hi_o=0x1234; res_valid at T+1 with DIV_ZERO_FAST_EN, at T+33 without.
REQ-034 annul at iteration 10 -> no res_valid, busy low next cycle, hi_o/lo_o unchanged; immediate new start 9/3 -> lo_o=3, hi_o=0.
REQ-035 rst at iteration 20 -> all outputs 0 next cycle, no res_valid pulse; start pulsed in BUSY -> no second result.
